// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit that holds the architectural HI/LO registers.
// MULT/MULTU use a shift-add multiplier and DIV/DIVU use a restoring divider.
// Each operation takes WIDTH iterations plus one sign-fix edge.
// MTHI/MTLO writes are accepted only while the unit is idle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d;       // 1: divide, 0: multiply
    logic               dz_q, dz_d;         // divide by zero
    logic               neg_q, neg_d;       // product / quotient sign flip
    logic               sign_a_q, sign_a_d; // remainder takes sign of a
    logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;   // raw a, returned in HI on divide by zero
    logic [2*WIDTH-1:0] acc_q, acc_d;       // product, or {remainder, dividend/quotient}
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operand conditioning and per-iteration arithmetic
    logic               is_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0]   fix_quot, fix_rem;

    // Datapath helpers shared by the accept, iterate and fix steps
    always_comb begin
        is_signed = ~op[0];
        abs_a     = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        abs_b     = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
        // Multiply step: conditionally add the multiplicand into the upper half
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        // Divide step: partial remainder shifted left with the next dividend bit, minus divisor.
        // The top bit of the trial result is set exactly when the trial went negative.
        div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        fix_prod  = neg_q ? (~acc_q + 1'b1) : acc_q;
        fix_quot  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        fix_rem   = sign_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state and datapath update; every target is defaulted to hold first
    // NOTE: defaulting every variable at the top of the block prevents latch inference.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        dz_d     = dz_q;
        neg_d    = neg_q;
        sign_a_d = sign_a_q;
        opnd_d   = opnd_q;
        a_raw_d  = a_raw_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wd;
                if (lo_we) lo_d = wd;
                if (start) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    div_d    = op[1];
                    dz_d     = op[1] && (b == '0);
                    neg_d    = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    sign_a_d = is_signed && a[WIDTH-1];
                    a_raw_d  = a;
                    if (op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, abs_a};
                        opnd_d = abs_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, abs_b};
                        opnd_d = abs_a;
                    end
                end
            end

            CALC: begin
                if (div_q) begin
                    if (!div_trial[WIDTH]) begin
                        acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end

            FIX: begin
                if (div_q) begin
                    if (dz_q) begin
                        lo_d = '1;
                        hi_d = a_raw_q;
                    end else begin
                        lo_d = fix_quot;
                        hi_d = fix_rem;
                    end
                end else begin
                    hi_d = fix_prod[2*WIDTH-1:WIDTH];
                    lo_d = fix_prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State register; an asynchronous reset aborts any running operation
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            dz_q     <= 1'b0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            dz_q     <= dz_d;
            neg_q    <= neg_d;
            sign_a_q <= sign_a_d;
            opnd_q   <= opnd_d;
            a_raw_q  <= a_raw_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed test of mult_div_unit.
// Expected results are hand-computed constants.
module tb_mult_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int errors = 0;
    int checks = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Present an operation so that it is sampled on the next rising edge (E0).
    task automatic start_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                            input logic hwe, input logic lwe, input logic [31:0] vwd);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        hi_we = hwe;
        lo_we = lwe;
        wd    = vwd;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        // Scramble operands: they must only matter on the accepting edge
        a     = $urandom;
        b     = $urandom;
        op    = ~o;
        check("busy_after_E0", {31'd0, busy}, 32'd1);
    endtask

    // Step through E1..E32, then E33, and check the result in the done cycle.
    // With inject set, a start request and an MTHI write are issued mid-operation.
    task automatic finish_op(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                             input logic inject, input logic [31:0] hold_hi);
        logic busy_ok;
        busy_ok = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1;
            if (!(busy === 1'b1 && done === 1'b0)) busy_ok = 1'b0;
            if (inject && i == 5) begin
                start = 1'b1;
                op    = OP_DIVU;
                a     = 32'd1;
                b     = 32'd1;
                hi_we = 1'b1;
                wd    = 32'hDEADBEEF;
            end
            if (inject && i == 6) begin
                start = 1'b0;
                hi_we = 1'b0;
                check({tag, "_hi_held_busy"}, hi, hold_hi);
            end
        end
        check({tag, "_busy_E1_E32"}, {31'd0, busy_ok}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_clr"}, {31'd0, busy}, 32'd0);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Multiply corners; the second and third start in the preceding done cycle
        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, '0);
        finish_op("multu_max", 32'hFFFFFFFE, 32'h00000001, 1'b0, '0);
        start_op(OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, '0);
        finish_op("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, '0);
        start_op(OP_MULT, 32'h80000000, 32'h80000000, 1'b0, 1'b0, '0);
        finish_op("mult_min", 32'h40000000, 32'h00000000, 1'b0, '0);

        // done is a single-cycle pulse and HI/LO hold afterwards
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("hold_hi", hi, 32'h40000000);
        check("hold_lo", lo, 32'h00000000);

        // Divide cases, including divide by zero
        start_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, '0);
        finish_op("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, '0);
        start_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, '0);
        finish_op("divu_100_7", 32'd2, 32'd14, 1'b0, '0);
        start_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, '0);
        finish_op("div_ovf", 32'h00000000, 32'h80000000, 1'b0, '0);
        start_op(OP_DIVU, 32'h12345678, 32'h0, 1'b0, 1'b0, '0);
        finish_op("divu_zero", 32'h12345678, 32'hFFFFFFFF, 1'b0, '0);
        start_op(OP_DIV, 32'hFFFFFFF0, 32'h0, 1'b0, 1'b0, '0);
        finish_op("div_zero_neg", 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0, '0);

        // start and MTHI while busy are ignored
        start_op(OP_MULTU, 32'd6, 32'd7, 1'b0, 1'b0, '0);
        finish_op("busy_ignore", 32'd0, 32'd42, 1'b1, 32'hFFFFFFF0);

        // MTLO in idle writes LO only
        @(negedge clk);
        lo_we = 1'b1;
        wd    = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        check("mtlo_lo", lo, 32'hCAFEF00D);
        check("mtlo_hi", hi, 32'h0);

        // start with MTHI in idle: the write lands, then FIX overwrites it
        start_op(OP_MULTU, 32'd2, 32'd3, 1'b1, 1'b0, 32'h11111111);
        check("mthi_with_start", hi, 32'h11111111);
        finish_op("mult_after_mthi", 32'd0, 32'd6, 1'b0, '0);

        // Reset in the middle of an operation aborts it
        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, '0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h6 & 32'h0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_op(OP_MULTU, 32'd3, 32'd5, 1'b0, 1'b0, '0);
        finish_op("multu_3_5", 32'd0, 32'd15, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the bench always ends on its own
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, downstream of the register file.
- It consumes the two register read operands (rd1 to a, rd2 to b) for MULT/MULTU/DIV/DIVU.
- It holds the 64-bit result in HI/LO for later MFHI/MFLO.
- It raises busy while computing so the control path can stall HI/LO consumers.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request to begin operation op on a, b
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  input  WIDTH  operand 1 (rs value, from register file rd1)
b  input  WIDTH  operand 2 (rt value, from register file rd2)
hi_we  input  1  MTHI: write wd into HI
lo_we  input  1  MTLO: write wd into LO
wd  input  WIDTH  MTHI/MTLO data
hi  output  WIDTH  HI register (mult upper product / div remainder)
lo  output  WIDTH  LO register (mult lower product / div quotient)
busy  output  1  operation in progress
done  output  1  one-cycle pulse when HI/LO take a new result

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0; all internal accumulators cleared.
- Reset mid-operation aborts the operation: no done pulse, and HI/LO read 0.

States:
- IDLE to CALC when start=1.
  - On the accepting edge E0, latch op and |a|, |b| (absolute values for signed ops, raw for unsigned).
  - Also latch the sign flags and a div-by-zero flag (b==0 for DIV/DIVU).
  - Clear the counter; busy=1 from E0.
- CALC runs WIDTH edges (E1..E32), one iteration per edge.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per edge.
- CALC to FIX when counter reaches WIDTH-1.
- FIX runs one edge (E33).
  - Apply sign correction and write HI/LO.
  - done=1 for exactly the following cycle; busy=0 after E33.
  - Return to IDLE.
- Latency: a result is visible on hi/lo, with done=1, in the cycle after E33, i.e. 33 cycles after start is sampled.
- A new start may be sampled in that same done cycle (back-to-back operation).

Arithmetic rules:
- MULT: the 64-bit product is negated if sign(a)^sign(b). {HI,LO}=product.
- DIV: quotient negated if sign(a)^sign(b); remainder takes sign(a). LO=quotient, HI=remainder.
- Results wrap modulo 2^WIDTH.
- 0x80000000 / -1 gives LO=0x80000000, HI=0.
- Divide by zero (DIV or DIVU): LO=all ones, HI=a (raw operand); no sign correction; latency unchanged.

Handshake and conflict rules:
- start while busy=1 is ignored; the running operation is unaffected.
- hi_we/lo_we while busy=1 are ignored.
- In IDLE, hi_we/lo_we write on the edge.
- start together with hi_we/lo_we in IDLE: the write takes effect and start is also accepted. The FIX write later overwrites both registers.
- a, b and op are sampled only on the accepting edge; changes during busy have no effect.
- hi and lo are registered outputs, stable except on a FIX edge or a permitted MTHI/MTLO edge.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy=1 for cycles 1..33; done in cycle 33; HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=0x12345678 b=0 -> LO=0xFFFFFFFF, HI=0x12345678, done at the normal latency.
- While busy: pulse start with new operands and assert hi_we with wd=0xDEADBEEF -> both ignored; the original result appears. Afterwards in IDLE, lo_we with wd=0xCAFEF00D -> lo=0xCAFEF00D next cycle, hi unchanged.
- Start MULTU, drive rst=0 at cycle 10 -> busy=0, hi=lo=0 immediately, no done pulse. After release, a fresh MULTU 3*5 -> LO=15, HI=0 in cycle 33.
